// File: rtl/decoder_pkg.sv
// Shared types and constants for the 3-to-8 one-hot decoder.
// Imported by the interface, the top-level decoder and its users.
package decoder_pkg;

    localparam int DEC_N_IN  = 3;
    localparam int DEC_N_OUT = 8;

    typedef logic [DEC_N_IN-1:0]  dec_sel_t;
    typedef logic [DEC_N_OUT-1:0] dec_onehot_t;

    localparam dec_onehot_t DEC_ALL_OFF = 8'h00;

    // True when exactly one line is active; convenient for monitors on the decode.
    function automatic logic dec_is_onehot(input dec_onehot_t v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < DEC_N_OUT; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return (cnt == 4'd1);
    endfunction

endpackage

// File: rtl/decoder_3to8_if.sv
// Select/strobe bundle for decoder_3to8; en exists only when DECODER_ENABLE_EN is defined.
interface decoder_3to8_if;
    import decoder_pkg::*;

    dec_sel_t    three_input;
    dec_onehot_t eight_output;
`ifdef DECODER_ENABLE_EN
    logic        en;
`endif

    modport master (
`ifdef DECODER_ENABLE_EN
        output en,
`endif
        output three_input,
        input  eight_output
    );

    modport slave (
`ifdef DECODER_ENABLE_EN
        input  en,
`endif
        input  three_input,
        output eight_output
    );

endinterface

// File: rtl/decoder_1to2.sv
// Enabled 1-to-2 decoder: the building block of the decode tree.
module decoder_1to2 (
    input  logic       en,
    input  logic       a,
    output logic [1:0] y
);

    assign y[0] = en & ~a;
    assign y[1] = en &  a;

endmodule

// File: rtl/decoder_3to8.sv
// Registered binary-to-one-hot decoder built as a tree of decoder_1to2 cells.
// Optional macro DECODER_ENABLE_EN adds an enable; otherwise the tree root is tied high.
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter int N_IN = DEC_N_IN
) (
    input  logic           clk,
    input  logic           rst,
    decoder_3to8_if.slave  bus
);

    localparam int N_OUT = 1 << N_IN;

    // Heap-numbered tree: node 1 is the root, node i feeds nodes 2i (bit=0) and 2i+1 (bit=1),
    // so leaf N_OUT+k is the line for code k.
    logic [2*N_OUT-1:1] node_s;
    logic [N_OUT-1:0]   out_d;
    logic [N_OUT-1:0]   out_q;

`ifdef DECODER_ENABLE_EN
    assign node_s[1] = bus.en;
`else
    assign node_s[1] = 1'b1;
`endif

    for (genvar lvl = 0; lvl < N_IN; lvl++) begin : g_level
        for (genvar j = 0; j < (1 << lvl); j++) begin : g_node
            localparam int IDX = (1 << lvl) + j;
            decoder_1to2 u_dec (
                .en (node_s[IDX]),
                .a  (bus.three_input[N_IN-1-lvl]),
                .y  (node_s[2*IDX +: 2])
            );
        end
    end

    // Leaf lines form the next registered decode.
    always_comb begin
        out_d = node_s[2*N_OUT-1:N_OUT];
    end

    // Output register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= DEC_ALL_OFF;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.eight_output = out_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: vector table, scoreboard queue, random one-hot run.
module tb_decoder_3to8;
    import decoder_pkg::*;

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  code;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    logic [7:0] exp_q[$];
    vec_t vecs[$];

    decoder_3to8_if bus ();

    decoder_3to8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive one cycle of stimulus, push its expected result, and compare after the edge.
    task automatic cycle(input logic r, input logic e, input logic [2:0] code,
                         input logic [7:0] want, input string name);
        logic [7:0] exp;
        rst = r;
        bus.three_input = code;
`ifdef DECODER_ENABLE_EN
        bus.en = e;
`endif
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: scoreboard empty, got %h expected entry", name, bus.eight_output);
        end else begin
            exp = exp_q.pop_front();
            check(name, bus.eight_output, exp);
        end
    endtask

    initial begin
        logic [2:0] c;
        logic [7:0] m;
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.three_input = 3'b000;
`ifdef DECODER_ENABLE_EN
        bus.en = 1'b1;
`endif

        vecs.push_back('{1'b1, 1'b1, 3'b101, 8'h00, "reset_1"});
        vecs.push_back('{1'b1, 1'b1, 3'b101, 8'h00, "reset_2"});
        vecs.push_back('{1'b0, 1'b1, 3'b101, 8'h20, "reset_release"});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 8'h01, "sweep_0"});
        vecs.push_back('{1'b0, 1'b1, 3'd1, 8'h02, "sweep_1"});
        vecs.push_back('{1'b0, 1'b1, 3'd2, 8'h04, "sweep_2"});
        vecs.push_back('{1'b0, 1'b1, 3'd3, 8'h08, "sweep_3"});
        vecs.push_back('{1'b0, 1'b1, 3'd4, 8'h10, "sweep_4"});
        vecs.push_back('{1'b0, 1'b1, 3'd5, 8'h20, "sweep_5"});
        vecs.push_back('{1'b0, 1'b1, 3'd6, 8'h40, "sweep_6"});
        vecs.push_back('{1'b0, 1'b1, 3'd7, 8'h80, "sweep_7"});
        vecs.push_back('{1'b0, 1'b1, 3'b010, 8'h04, "pre_midreset"});
        vecs.push_back('{1'b1, 1'b1, 3'b011, 8'h00, "midreset_discard"});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 8'h08, "midreset_recover"});
`ifdef DECODER_ENABLE_EN
        vecs.push_back('{1'b0, 1'b0, 3'b110, 8'h00, "en_low"});
        vecs.push_back('{1'b0, 1'b1, 3'b110, 8'h40, "en_high"});
        vecs.push_back('{1'b0, 1'b0, 3'b001, 8'h00, "en_low_again"});
        vecs.push_back('{1'b1, 1'b1, 3'b110, 8'h00, "rst_over_en"});
        vecs.push_back('{1'b0, 1'b1, 3'b100, 8'h10, "en_recover"});
`endif

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].code, vecs[i].exp, vecs[i].name);
        end

        // Latency: input change between edges must not reach the output early.
        cycle(1'b0, 1'b1, 3'b000, 8'h01, "lat_load0");
        bus.three_input = 3'b111;
        #3;
        check("lat_hold", bus.eight_output, 8'h01);
        cycle(1'b0, 1'b1, 3'b111, 8'h80, "lat_load7");

        // Random codes: exact scoreboard compare plus one-hot property.
        for (int k = 0; k < 1000; k++) begin
            c = 3'($urandom_range(0, 7));
            m = 8'h01 << c;
            cycle(1'b0, 1'b1, c, m, "rand_decode");
            n_total++;
            if ($countones(bus.eight_output) == 1) begin
                n_pass++;
            end else begin
                $display("FAIL rand_onehot: got %h expected popcount 1", bus.eight_output);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
